// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin arbiter sharing one AXI-Stream output through a 2-entry store
module stream_rr_arbiter #(
  parameter int DWIDTH = 32,
  parameter int NUM_SRC = 4,
  localparam int IDW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]         m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [IDW-1:0]            m_axis_tid,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic [IDW-1:0]            grant_idx
);
  localparam int EW = IDW + 1 + DWIDTH;
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick, cand;
  logic found, acc, rd, last_in;
  logic [1:0] wr_q, wr_d, rd_q, rd_d, count;
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  function automatic logic [IDW-1:0] wrap(input logic [IDW:0] v);
    return v >= (IDW+1)'(NUM_SRC) ? IDW'(v - (IDW+1)'(NUM_SRC)) : v[IDW-1:0];
  endfunction
  always_comb begin
    pick = rr_ptr_q;
    found = 1'b0;
    cand = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = wrap({1'b0, rr_ptr_q} + (IDW+1)'(i));
      if (s_axis_tvalid[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  assign count = wr_q - rd_q;
  assign s_axis_tready = (state_q == LOCKED && count != 2'd2) ? NUM_SRC'(1) << grant_q : '0;
  assign acc = |(s_axis_tready & s_axis_tvalid);
  assign last_in = s_axis_tlast[grant_q];
  assign m_axis_tvalid = count != 2'd0;
  assign rd = m_axis_tvalid & m_axis_tready;
  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = mem_q[rd_q[0]];
  assign busy = state_q == LOCKED;
  assign grant_idx = grant_q;
  always_comb begin
    state_d = state_q == IDLE ? (found ? LOCKED : IDLE) : (acc && last_in ? IDLE : LOCKED);
    grant_d = state_q == IDLE && found ? pick : grant_q;
    rr_ptr_d = acc && last_in ? (grant_q == IDW'(NUM_SRC - 1) ? '0 : grant_q + 1'b1) : rr_ptr_q;
    wr_d = wr_q + {1'b0, acc};
    rd_d = rd_q + {1'b0, rd};
    mem_d = mem_q;
    if (acc) mem_d[wr_q[0]] = {grant_q, last_in, s_axis_tdata[grant_q*DWIDTH +: DWIDTH]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
endmodule
